// File: rtl/feature_loader_pp_if.sv
// Write-beat / read-bank bundle between the activation fetch path, the staging
// buffer and the compute array's feature inputs.
interface feature_loader_pp_if #(
  parameter int inputWidth   = 256,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int addrWidth    = 8,
  parameter int maskWidth    = 10,
  parameter int countWidth   = 8
);
  localparam int EPB = inputWidth / elementWidth;

  logic                                in_valid;
  logic                                in_ready;
  logic [inputWidth-1:0]               in_data;
  logic [addrWidth-1:0]                in_addr;
  logic [EPB-1:0]                      in_strb;
  logic                                in_last;
  logic                                out_valid;
  logic                                out_release;
  logic [numElements*elementWidth-1:0] data_o;
  logic [maskWidth-1:0]                mask_start;
  logic [maskWidth-1:0]                mask_end;
  logic [countWidth-1:0]               fill_count;
  logic                                addr_err;

  modport master (
    output in_valid, in_data, in_addr, in_strb, in_last, out_release,
           mask_start, mask_end,
    input  in_ready, out_valid, data_o, fill_count, addr_err
  );

  modport slave (
    input  in_valid, in_data, in_addr, in_strb, in_last, out_release,
           mask_start, mask_end,
    output in_ready, out_valid, data_o, fill_count, addr_err
  );
endinterface

// File: rtl/feature_loader_pp.sv
// Double-buffered feature staging buffer: strobed, wrapping element writes into
// the fill bank; masked array-wide vector out of the read bank; swap on last/release.
module feature_loader_pp #(
  parameter int inputWidth   = 256,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int addrWidth    = 8,
  parameter int maskWidth    = 10,
  parameter int countWidth   = 8
) (
  input logic               clk,
  input logic               nrst,
  feature_loader_pp_if.slave bus
);
  localparam int EPB = inputWidth / elementWidth;
  localparam int IW  = (numElements > 1) ? $clog2(numElements) : 1;
  localparam logic [addrWidth:0] NE_W = (addrWidth + 1)'(numElements);

  typedef enum logic {FILL, PEND} state_t;

  state_t                  state;
  logic                    sel;
  logic                    rd_sel;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    addr_err_q;
  logic [countWidth-1:0]   fill_count_q;

  logic [elementWidth-1:0] bank [2][numElements];

  logic                    accept;
  logic                    commit;
  logic                    addr_ok;
  logic                    swap;
  logic [addrWidth:0]      k_sum  [EPB];
  logic [IW-1:0]           wr_idx [EPB];

  assign rd_sel = ~sel;

  always_comb begin
    accept  = bus.in_valid & in_ready_q;
    commit  = accept & bus.in_last;
    addr_ok = ({1'b0, bus.in_addr} < NE_W);
    // In PEND the fill bank is already committed; a release alone completes the swap.
    swap    = (state == PEND) ? bus.out_release
                              : (commit && (!out_valid_q || bus.out_release));
    for (int j = 0; j < EPB; j++) begin
      k_sum[j]  = {1'b0, bus.in_addr} + (addrWidth + 1)'(j);
      wr_idx[j] = IW'((k_sum[j] >= NE_W) ? (k_sum[j] - NE_W) : k_sum[j]);
    end
  end

  // Control FSM with registered handshake/status outputs.
  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= FILL;
      sel          <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      fill_count_q <= '0;
    end else begin
      if (accept && !addr_ok)
        addr_err_q <= 1'b1;

      if (swap) begin
        sel          <= ~sel;
        out_valid_q  <= 1'b1;
        fill_count_q <= '0;
        state        <= FILL;
        in_ready_q   <= 1'b1;
      end else begin
        if (accept && (fill_count_q != '1))
          fill_count_q <= fill_count_q + 1'b1;
        if (commit) begin
          state      <= PEND;
          in_ready_q <= 1'b0;
        end else if (bus.out_release) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  // NOTE: both banks are reset explicitly because data_o must read zero straight
  // out of reset and a reset mid-tile has to discard partial contents.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < numElements; i++)
          bank[b][i] <= '0;
    end else begin
      // The old read bank becomes the next fill bank and must start clean.
      if (swap)
        for (int i = 0; i < numElements; i++)
          bank[rd_sel][i] <= '0;
      if (accept && addr_ok)
        for (int j = 0; j < EPB; j++)
          if (bus.in_strb[j])
            bank[sel][wr_idx[j]] <= bus.in_data[(EPB-1-j)*elementWidth +: elementWidth];
    end
  end

  // Element indices never reach numElements, so comparing against the raw
  // mask_end behaves exactly like comparing against the clamped bound.
  for (genvar i = 0; i < numElements; i++) begin : g_mask
    localparam logic [maskWidth-1:0] IDX = maskWidth'(i);
    assign bus.data_o[i*elementWidth +: elementWidth] =
      ((bus.mask_start <= IDX) && (IDX < bus.mask_end)) ? bank[rd_sel][i] : '0;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fill_count = fill_count_q;
  assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_feature_loader_pp.sv
// Directed bench for feature_loader_pp: a behavioural tile model pushes expected
// read-bank vectors on each commit; they are popped when the swap shows on data_o.
module tb_feature_loader_pp;
  localparam int NE  = 128;
  localparam int EW  = 8;
  localparam int EPB = 32;
  localparam int DW  = 256;
  localparam int VW  = NE * EW;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  feature_loader_pp_if bus ();
  feature_loader_pp dut (.clk(clk), .nrst(nrst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] mdl      = '0;
  logic [VW-1:0] cur_tile = '0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mask_vec(input logic [VW-1:0] t, input int s, input int e);
    logic [VW-1:0] r = '0;
    for (int i = 0; i < NE; i++)
      if (i >= s && i < e) r[i*EW +: EW] = t[i*EW +: EW];
    return r;
  endfunction

  // One accepted beat (only called while the buffer is in FILL); element j = base + j.
  task automatic beat(input int addr, input int base, input logic [EPB-1:0] strb,
                      input logic last, input logic rel);
    logic [DW-1:0] d = '0;
    for (int j = 0; j < EPB; j++) d[(EPB-1-j)*EW +: EW] = 8'(base + j);
    bus.in_valid    = 1'b1;
    bus.in_addr     = 8'(addr);
    bus.in_data     = d;
    bus.in_strb     = strb;
    bus.in_last     = last;
    bus.out_release = rel;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_strb     = '0;
    bus.out_release = 1'b0;
    if (addr < NE)
      for (int j = 0; j < EPB; j++)
        if (strb[j]) mdl[((addr + j) % NE)*EW +: EW] = 8'(base + j);
    if (last) begin
      exp_q.push_back(mdl);
      mdl = '0;
    end
  endtask

  task automatic expect_tile(input string tag);
    check({tag, "_queued"}, VW'(exp_q.size() != 0), VW'(1));
    if (exp_q.size() != 0) begin
      cur_tile = exp_q.pop_front();
      check(tag, bus.data_o, mask_vec(cur_tile, int'(bus.mask_start), int'(bus.mask_end)));
    end
  endtask

  task automatic pulse_release();
    bus.out_release = 1'b1;
    @(posedge clk); #1;
    bus.out_release = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_strb = '0;
    bus.in_last = 1'b0; bus.out_release = 1'b0;
    bus.mask_start = 10'd0; bus.mask_end = 10'd128;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  bus.data_o,     '0);
    check("rst_ready", bus.in_ready,   VW'(1));
    check("rst_valid", bus.out_valid,  VW'(0));
    check("rst_count", bus.fill_count, VW'(0));
    check("rst_err",   bus.addr_err,   VW'(0));
    nrst = 1'b1;
    @(posedge clk); #1;
    check("idle_data",  bus.data_o,   '0);
    check("idle_ready", bus.in_ready, VW'(1));

    // Tile 1: four beats of element = index, last on the fourth
    beat(0,  0,  '1, 1'b0, 1'b0);
    beat(32, 32, '1, 1'b0, 1'b0);
    beat(64, 64, '1, 1'b0, 1'b0);
    check("t1_count3", bus.fill_count, VW'(3));
    check("t1_novalid", bus.out_valid, VW'(0));
    check("t1_nodata", bus.data_o, '0);
    beat(96, 96, '1, 1'b1, 1'b0);
    check("t1_valid", bus.out_valid, VW'(1));
    check("t1_count0", bus.fill_count, VW'(0));
    expect_tile("t1_tile");
    check("t1_elem77", bus.data_o[77*EW +: EW], VW'(77));

    // Mask windows
    bus.mask_start = 10'd10; bus.mask_end = 10'd20; #1;
    check("mask_10_20", bus.data_o, mask_vec(cur_tile, 10, 20));
    check("mask_e9",  bus.data_o[9*EW +: EW],  VW'(0));
    check("mask_e19", bus.data_o[19*EW +: EW], VW'(19));
    bus.mask_start = 10'd20; bus.mask_end = 10'd10; #1;
    check("mask_inverted", bus.data_o, '0);
    bus.mask_start = 10'd120; bus.mask_end = 10'd700; #1;
    check("mask_clamp", bus.data_o, mask_vec(cur_tile, 120, 128));
    bus.mask_start = 10'd0; bus.mask_end = 10'd128; #1;

    // Wrap and strobe, with release in the same cycle as the last beat
    beat(120, 8'hA0, 32'h0000_FFFF, 1'b1, 1'b1);
    check("wrap_valid", bus.out_valid, VW'(1));
    check("wrap_ready", bus.in_ready,  VW'(1));
    expect_tile("wrap_tile");
    check("wrap_e127", bus.data_o[127*EW +: EW], VW'(8'hA7));
    check("wrap_e0",   bus.data_o[0*EW +: EW],   VW'(8'hA8));
    check("wrap_e8",   bus.data_o[8*EW +: EW],   VW'(0));
    check("wrap_e23",  bus.data_o[23*EW +: EW],  VW'(0));

    // Overlap: tile B committed while the wrap tile is still being read
    beat(40, 8'h50, '1, 1'b1, 1'b0);
    check("pend_ready", bus.in_ready,   VW'(0));
    check("pend_valid", bus.out_valid,  VW'(1));
    check("pend_hold",  bus.data_o,     cur_tile);
    check("pend_count", bus.fill_count, VW'(1));
    bus.in_valid = 1'b1; bus.in_addr = 8'd0; bus.in_data = {DW{1'b1}}; bus.in_strb = '1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_strb = '0;
    check("pend_blocked", bus.fill_count, VW'(1));
    check("pend_hold2",   bus.data_o,     cur_tile);
    pulse_release();
    check("swap_ready", bus.in_ready, VW'(1));
    check("swap_valid", bus.out_valid, VW'(1));
    check("swap_count", bus.fill_count, VW'(0));
    expect_tile("tileb");

    // Release with no commit drops out_valid but holds contents; a second is ignored
    pulse_release();
    check("rel_valid", bus.out_valid, VW'(0));
    check("rel_hold",  bus.data_o,    cur_tile);
    pulse_release();
    check("rel_ignored", bus.out_valid, VW'(0));

    // Address error: nothing written, sticky flag, count still advances
    beat(200, 8'h11, '1, 1'b0, 1'b0);
    check("err_flag",  bus.addr_err,   VW'(1));
    check("err_count", bus.fill_count, VW'(1));
    beat(5, 8'h77, 32'h0000_0001, 1'b1, 1'b0);
    check("err_sticky", bus.addr_err, VW'(1));
    expect_tile("err_tile");
    check("err_e5", bus.data_o[5*EW +: EW], VW'(8'h77));

    // Reset asserted while in PEND
    beat(0, 8'h01, '1, 1'b1, 1'b0);
    check("pend2_ready", bus.in_ready, VW'(0));
    #3 nrst = 1'b0;
    #1;
    check("arst_data",  bus.data_o,     '0);
    check("arst_ready", bus.in_ready,   VW'(1));
    check("arst_valid", bus.out_valid,  VW'(0));
    check("arst_count", bus.fill_count, VW'(0));
    check("arst_err",   bus.addr_err,   VW'(0));
    exp_q.delete();
    mdl = '0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Recovery tile after reset
    beat(0, 8'h33, '1, 1'b1, 1'b0);
    check("post_valid", bus.out_valid, VW'(1));
    expect_tile("post_tile");
    check("queue_drained", VW'(exp_q.size()), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
